// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default operand width for serial_adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int SERIAL_ADDER_WIDTH_DEF = 8;
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit full-adder cell used by serial_adder for its per-bit add.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial a+b+c_in, LSB first, one bit per cycle with valid/ready handshakes.
// Defining SERIAL_ADDER_OVF_EN adds the ovf port reporting signed overflow in DONE.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic carry_q, carry_d, s_bit, c_bit;
  full_adder u_fa (
    .a_i(a_q[cnt_q]),
    .b_i(b_q[cnt_q]),
    .c_i(carry_q),
    .s_o(s_bit),
    .c_o(c_bit)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        carry_d = c_in;
        res_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: if (abort) state_d = IDLE;
      else begin
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_bit;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == LAST) ? DONE : RUN;
      end
      DONE: state_d = (abort || out_ready) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = res_q;
  assign c_out     = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the MSB is the carry register as the last bit is being added.
  logic cmsb_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmsb_q <= 1'b0;
    else if (state_q == RUN && cnt_q == LAST) cmsb_q <= carry_q;
  end
  assign ovf = (state_q == DONE) & (cmsb_q ^ carry_q);
`endif
endmodule
